// File: rtl/req_gnt_clocking_if.sv
// Request/grant clocking adapter: three stimulus channels drive one registered req
// through per-channel output skew pipelines and get per-channel skewed gnt samples.
module req_gnt_clocking_if #(
  parameter int OUT_SKEW0 = 0,
  parameter int OUT_SKEW1 = 2,
  parameter int OUT_SKEW2 = 5,
  parameter int IN_SKEW0  = 0,
  parameter int IN_SKEW1  = 2,
  parameter int IN_SKEW2  = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic drv_en0,
  input  logic drv_en1,
  input  logic drv_en2,
  input  logic drv_val0,
  input  logic drv_val1,
  input  logic drv_val2,
  output logic req,
  input  logic gnt,
  output logic req_smp,
  output logic gnt_smp0,
  output logic gnt_smp1,
  output logic gnt_smp2
);

  function automatic bit in_range(input int v);
    return (v >= 0) && (v <= 15);
  endfunction

  localparam bit SKEWS_OK = in_range(OUT_SKEW0) && in_range(OUT_SKEW1) && in_range(OUT_SKEW2) &&
                            in_range(IN_SKEW0)  && in_range(IN_SKEW1)  && in_range(IN_SKEW2);

  if (!SKEWS_OK) begin : g_bad_skew
    $error("req_gnt_clocking_if: skew parameters must lie in 0..15");
  end

  localparam logic [11:0] OUT_SKEWS = {4'(OUT_SKEW2), 4'(OUT_SKEW1), 4'(OUT_SKEW0)};
  localparam logic [11:0] IN_SKEWS  = {4'(IN_SKEW2),  4'(IN_SKEW1),  4'(IN_SKEW0)};

  logic [2:0] drv_en;
  logic [2:0] drv_val;
  logic [2:0] mat_vld;
  logic [2:0] mat_val;
  logic [2:0] gnt_smp_d;
  logic [2:0] gnt_smp_q;
  logic       req_d;
  logic       req_q;
  logic       req_smp_d;
  logic       req_smp_q;

  assign drv_en  = {drv_en2, drv_en1, drv_en0};
  assign drv_val = {drv_val2, drv_val1, drv_val0};

  for (genvar k = 0; k < 3; k++) begin : g_ch
    localparam int OS = int'(OUT_SKEWS[4*k +: 4]);
    localparam int IS = int'(IN_SKEWS[4*k +: 4]);

    // Zero skew bypasses the pipeline so the drive lands on req at its own edge.
    if (OS == 0) begin : g_drv_direct
      assign mat_vld[k] = drv_en[k];
      assign mat_val[k] = drv_val[k];
    end else begin : g_drv_pipe
      logic [OS-1:0] vld_q;
      logic [OS-1:0] vld_d;
      logic [OS-1:0] val_q;
      logic [OS-1:0] val_d;

      always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = drv_en[k];
        val_d    = val_q << 1;
        val_d[0] = drv_val[k];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
          val_q <= '0;
        end else begin
          vld_q <= vld_d;
          val_q <= val_d;
        end
      end

      assign mat_vld[k] = vld_q[OS-1];
      assign mat_val[k] = val_q[OS-1];
    end

    if (IS == 0) begin : g_smp_direct
      assign gnt_smp_d[k] = gnt;
    end else begin : g_smp_chain
      logic [IS-1:0] chain_q;
      logic [IS-1:0] chain_d;

      always_comb begin
        chain_d    = chain_q << 1;
        chain_d[0] = gnt;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain_q <= '0;
        end else begin
          chain_q <= chain_d;
        end
      end

      assign gnt_smp_d[k] = chain_q[IS-1];
    end
  end

  // Lowest channel index wins when several drives mature on the same edge.
  always_comb begin
    req_d     = req_q;
    req_smp_d = req_q;
    if (mat_vld[0]) begin
      req_d = mat_val[0];
    end else if (mat_vld[1]) begin
      req_d = mat_val[1];
    end else if (mat_vld[2]) begin
      req_d = mat_val[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      req_smp_q <= 1'b0;
      gnt_smp_q <= '0;
    end else begin
      req_q     <= req_d;
      req_smp_q <= req_smp_d;
      gnt_smp_q <= gnt_smp_d;
    end
  end

  assign req      = req_q;
  assign req_smp  = req_smp_q;
  assign gnt_smp0 = gnt_smp_q[0];
  assign gnt_smp1 = gnt_smp_q[1];
  assign gnt_smp2 = gnt_smp_q[2];

endmodule

// File: tb/tb_req_gnt_clocking_if.sv
// Testbench for req_gnt_clocking_if: directed drives and grant pulses checked
// against a scoreboard of pending drives and grant samples keyed by due edge.
module tb_req_gnt_clocking_if;

  localparam int OS0 = 0;
  localparam int OS1 = 2;
  localparam int OS2 = 5;
  localparam int IS0 = 0;
  localparam int IS1 = 2;
  localparam int IS2 = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drv_en0 = 1'b0, drv_en1 = 1'b0, drv_en2 = 1'b0;
  logic drv_val0 = 1'b0, drv_val1 = 1'b0, drv_val2 = 1'b0;
  logic gnt = 1'b0;
  logic req, req_smp, gnt_smp0, gnt_smp1, gnt_smp2;

  always #5 clk = ~clk;

  req_gnt_clocking_if #(
    .OUT_SKEW0(OS0), .OUT_SKEW1(OS1), .OUT_SKEW2(OS2),
    .IN_SKEW0(IS0),  .IN_SKEW1(IS1),  .IN_SKEW2(IS2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .drv_en0(drv_en0), .drv_en1(drv_en1), .drv_en2(drv_en2),
    .drv_val0(drv_val0), .drv_val1(drv_val1), .drv_val2(drv_val2),
    .req(req), .gnt(gnt), .req_smp(req_smp),
    .gnt_smp0(gnt_smp0), .gnt_smp1(gnt_smp1), .gnt_smp2(gnt_smp2)
  );

  typedef struct {
    int   due;
    int   ch;
    logic val;
  } drive_t;

  typedef struct {
    int   due;
    logic val;
  } sample_t;

  drive_t  drv_q[$];
  sample_t gnt_q0[$];
  sample_t gnt_q1[$];
  sample_t gnt_q2[$];

  int edge_no = 0;
  int checks = 0;
  int failures = 0;
  logic exp_req = 1'b0;
  logic exp_req_smp = 1'b0;
  logic [2:0] exp_smp = 3'b000;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s edge=%0d observed=%0b expected=%0b", tag, edge_no, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check_bit("req", req, exp_req);
    check_bit("req_smp", req_smp, exp_req_smp);
    check_bit("gnt_smp0", gnt_smp0, exp_smp[0]);
    check_bit("gnt_smp1", gnt_smp1, exp_smp[1]);
    check_bit("gnt_smp2", gnt_smp2, exp_smp[2]);
  endtask

  task automatic applyStimulus(input logic e0, input logic v0, input logic e1, input logic v1,
                               input logic e2, input logic v2, input logic g);
    drv_en0 = e0; drv_val0 = v0;
    drv_en1 = e1; drv_val1 = v1;
    drv_en2 = e2; drv_val2 = v2;
    gnt     = g;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_model();
    drv_q.delete();
    gnt_q0.delete();
    gnt_q1.delete();
    gnt_q2.delete();
    exp_req     = 1'b0;
    exp_req_smp = 1'b0;
    exp_smp     = 3'b000;
  endtask

  task automatic push_drive(input int ch, input int skew, input logic val);
    drive_t d;
    d.due = edge_no + skew;
    d.ch  = ch;
    d.val = val;
    drv_q.push_back(d);
  endtask

  function automatic logic pop_sample(inout sample_t q[$]);
    if (q.size() > 0 && q[0].due == edge_no) begin
      sample_t s;
      s = q.pop_front();
      return s.val;
    end
    return 1'b0;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      edge_no++;
      if (!rst_n) begin
        clear_model();
      end else begin
        sample_t s;
        drive_t  keep[$];
        int      best_ch;
        logic    best_val;
        exp_req_smp = exp_req;
        if (drv_en0) push_drive(0, OS0, drv_val0);
        if (drv_en1) push_drive(1, OS1, drv_val1);
        if (drv_en2) push_drive(2, OS2, drv_val2);
        s.val = gnt;
        s.due = edge_no + IS0; gnt_q0.push_back(s);
        s.due = edge_no + IS1; gnt_q1.push_back(s);
        s.due = edge_no + IS2; gnt_q2.push_back(s);
        best_ch  = 3;
        best_val = 1'b0;
        foreach (drv_q[j]) begin
          if (drv_q[j].due == edge_no) begin
            if (drv_q[j].ch < best_ch) begin
              best_ch  = drv_q[j].ch;
              best_val = drv_q[j].val;
            end
          end else begin
            keep.push_back(drv_q[j]);
          end
        end
        drv_q = keep;
        if (best_ch < 3) exp_req = best_val;
        exp_smp[0] = pop_sample(gnt_q0);
        exp_smp[1] = pop_sample(gnt_q1);
        exp_smp[2] = pop_sample(gnt_q2);
      end
      #1;
      checkOutput();
    end
  endtask

  initial begin
    $display("[TB] start");
    #1;
    checkOutput();

    // Reset held with random activity on every input.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
      tick(1);
    end
    idle();
    rst_n = 1'b1;
    tick(10);

    // Channel 0, zero skew, then toggle from req_smp.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    idle();
    tick(3);
    applyStimulus(1'b1, ~req_smp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    idle();
    tick(2);

    // Channel 1 then channel 2 with their skews.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    idle();
    tick(7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    idle();
    tick(7);

    // Collision: ch2 and ch0 mature together.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    idle();
    tick(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    idle();
    tick(3);

    // Collision: ch2 and ch1 mature together.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    idle();
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    idle();
    tick(4);

    // Back-to-back drives on channel 1.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); tick(1);
    idle();
    tick(4);

    // Single-cycle grant pulse.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    idle();
    tick(8);

    // Random mix, including collisions and grant activity.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom),
                    1'($urandom_range(0, 2) == 0), 1'($urandom),
                    1'($urandom_range(0, 1) == 0), 1'($urandom),
                    1'($urandom));
      tick(1);
    end
    idle();
    tick(6);

    // Asynchronous reset mid-flight drops the pending drives.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);
    idle();
    tick(1);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    checkOutput();
    tick(2);
    rst_n = 1'b1;
    tick(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
